// File: rtl/cpu_pkg.sv
// cpu_pkg -- constants and helpers shared by the integer register file.
//
// Contents:
//   REG_DW    default data width of an architectural register
//   REG_NUM   default number of architectural registers
//   REG_AW    default register address width (log2 of REG_NUM)
//   REG_LINK  register written by the jal link port
//   REG_ZERO  hard-wired zero register
//   clog2()   ceiling log2, used to derive address widths from depths
package cpu_pkg;

  localparam int REG_DW   = 32;
  localparam int REG_NUM  = 32;
  localparam int REG_AW   = 5;
  localparam int REG_LINK = 31;
  localparam int REG_ZERO = 0;

  // Ceiling log2 with a floor of 1, so a 2-entry file still gets a 1-bit address.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        result++;
        rem = rem >> 1;
      end
    end
    if (result == 0) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- per-register busy bits for hazard detection.
//
// Decode marks a destination pending with busy_set; writeback (we) or the
// link port (link_we) retires it. A set and a clear on the same register in
// the same cycle leaves it busy, because the set belongs to a newer producer.
//
// Ports:
//   CLK, Reset   clock, asynchronous active-low reset
//   we, waddr    writeback write (clears busy[waddr])
//   link_we      link write (clears busy[LINK_REG])
//   busy_set     mark busy_addr as pending
//   busy_addr    destination register to mark
//   rd_addr      packed read addresses, NR ports of AW bits
//   busy         registered scoreboard vector
//   rd_hazard    combinational per-port hazard flag
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int DEPTH    = REG_NUM,
  parameter int AW       = clog2(DEPTH),
  parameter int NR       = 2,
  parameter int LINK_REG = REG_LINK
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic             link_we,
  input  logic             busy_set,
  input  logic [AW-1:0]    busy_addr,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [DEPTH-1:0] busy,
  output logic [NR-1:0]    rd_hazard
);

  logic             wbWrite;
  logic             linkWrite;
  logic [DEPTH-1:0] busyNext;

  // Writes to the zero register never happen, so they clear nothing.
  assign wbWrite   = we && (waddr != '0);
  assign linkWrite = link_we && (LINK_REG != REG_ZERO);

  always_comb begin
    // NOTE: a full default before any conditional update keeps always_comb
    // free of inferred latches; later statements override earlier ones, so
    // the set below takes priority over both clears.
    busyNext = busy;
    for (int i = 1; i < DEPTH; i++) begin
      if (linkWrite && (i == LINK_REG))        busyNext[i] = 1'b0;
      if (wbWrite && (waddr == AW'(i)))        busyNext[i] = 1'b0;
      if (busy_set && (busy_addr == AW'(i)))   busyNext[i] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) busy <= '0;
    else        busy <= busyNext;
  end

  // A register being written this very cycle is not a hazard: its value
  // reaches the read port through the write-first bypass.
  for (genvar k = 0; k < NR; k++) begin : g_hazard
    logic [AW-1:0] addr;
    assign addr = rd_addr[k*AW +: AW];
    assign rd_hazard[k] = busy[addr]
                          && !(wbWrite && (waddr == addr))
                          && !(linkWrite && (addr == AW'(LINK_REG)))
                          && (addr != '0);
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port integer register file.
//
// Storage array with a writeback port and a dedicated link (jal) port,
// NR registered read ports with write-first bypass and a shared read enable
// that holds the outputs during pipeline stalls, plus a busy scoreboard.
// Register 0 reads as zero and ignores writes.
//
// Ports:
//   CLK, Reset   clock, asynchronous active-low reset
//   rd_en        read enable for all ports; 0 holds rd_data
//   rd_addr      packed read addresses, port k at [k*AW +: AW]
//   rd_data      packed registered read data, port k at [k*DW +: DW]
//   rd_hazard    per-port: addressed register busy and not written this cycle
//   we/waddr/wdata        writeback write port
//   link_we/link_wdata    link write port, targets LINK_REG, wins over writeback
//   busy_set/busy_addr    mark a destination register pending
//   busy         registered scoreboard vector
module regfile_mp
  import cpu_pkg::*;
#(
  parameter int DW       = REG_DW,
  parameter int DEPTH    = REG_NUM,
  parameter int AW       = clog2(DEPTH),
  parameter int NR       = 2,
  parameter int LINK_REG = REG_LINK
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             rd_en,
  input  logic [NR*AW-1:0] rd_addr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]    rd_hazard,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             link_we,
  input  logic [DW-1:0]    link_wdata,
  input  logic             busy_set,
  input  logic [AW-1:0]    busy_addr,
  output logic [DEPTH-1:0] busy
);

  logic          wbWrite;
  logic          linkWrite;
  logic [DW-1:0] regFile [DEPTH];

  assign wbWrite   = we && (waddr != '0);
  assign linkWrite = link_we && (LINK_REG != REG_ZERO);

  // NOTE: the array is built from resettable flops on purpose -- every
  // architectural register must read 0 after reset, so it cannot map to a RAM.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) regFile[i] <= '0;
    end else begin
      // Entry 0 is never written and stays at its reset value of zero.
      for (int i = 1; i < DEPTH; i++) begin
        if (linkWrite && (i == LINK_REG))   regFile[i] <= link_wdata;
        else if (wbWrite && (waddr == AW'(i))) regFile[i] <= wdata;
      end
    end
  end

  // Read ports: the value captured is what the register holds after this
  // edge's writes, so the bypass order mirrors the write priority.
  for (genvar k = 0; k < NR; k++) begin : g_read
    logic [AW-1:0] addr;
    logic [DW-1:0] nextData;
    logic [DW-1:0] readReg;

    assign addr = rd_addr[k*AW +: AW];

    always_comb begin
      nextData = regFile[addr];
      if (wbWrite && (waddr == addr))             nextData = wdata;
      if (linkWrite && (addr == AW'(LINK_REG)))   nextData = link_wdata;
      if (addr == '0)                             nextData = '0;
    end

    // A stalled port keeps its old value even if that register is rewritten.
    always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)     readReg <= '0;
      else if (rd_en) readReg <= nextData;
    end

    assign rd_data[k*DW +: DW] = readReg;
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NR       (NR),
    .LINK_REG (LINK_REG)
  ) u_scoreboard (
    .CLK       (CLK),
    .Reset     (Reset),
    .we        (we),
    .waddr     (waddr),
    .link_we   (link_we),
    .busy_set  (busy_set),
    .busy_addr (busy_addr),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .rd_hazard (rd_hazard)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- self-checking bench for regfile_mp (default parameters).
// A behavioural model updates registers and busy bits in write order; each
// clocked step pushes the expected read data and busy vector to a queue and
// pops it once the DUT has produced the post-edge outputs.
module tb_regfile_mp;

  logic        clk;
  logic        Reset;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_hazard;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        link_we;
  logic [31:0] link_wdata;
  logic        busy_set;
  logic [4:0]  busy_addr;
  logic [31:0] busy;

  typedef struct {
    logic [63:0] rd;
    logic [31:0] bsy;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic [31:0] m_rd   [2];
  int          checks;
  int          errors;

  regfile_mp dut (
    .CLK        (clk),
    .Reset      (Reset),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_hazard  (rd_hazard),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .link_we    (link_we),
    .link_wdata (link_wdata),
    .busy_set   (busy_set),
    .busy_addr  (busy_addr),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    rd_en = 1'b0; rd_addr = '0; we = 1'b0; waddr = '0; wdata = '0;
    link_we = 1'b0; link_wdata = '0; busy_set = 1'b0; busy_addr = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
    m_rd[0] = '0;
    m_rd[1] = '0;
    sb_q.delete();
  endtask

  // One clock: check hazards against current inputs, advance the model,
  // queue the expectation, clock the DUT, then compare.
  task automatic step(input string name);
    exp_t        e;
    logic [1:0]  hz;
    logic [4:0]  a;
    #1;
    for (int k = 0; k < 2; k++) begin
      a = rd_addr[k*5 +: 5];
      hz[k] = m_busy[a] && !(we && waddr == a) && !(link_we && a == 5'd31) && (a != 5'd0);
    end
    checks++;
    if (rd_hazard !== hz) begin
      errors++;
      $display("FAIL %s rd_hazard: got %b expected %b", name, rd_hazard, hz);
    end
    if (we && waddr != 5'd0) m_regs[waddr] = wdata;
    if (link_we) m_regs[31] = link_wdata;
    if (we && waddr != 5'd0) m_busy[waddr] = 1'b0;
    if (link_we) m_busy[31] = 1'b0;
    if (busy_set && busy_addr != 5'd0) m_busy[busy_addr] = 1'b1;
    if (rd_en) begin
      for (int k = 0; k < 2; k++) begin
        a = rd_addr[k*5 +: 5];
        m_rd[k] = (a == 5'd0) ? 32'd0 : m_regs[a];
      end
    end
    e.rd  = {m_rd[1], m_rd[0]};
    e.bsy = m_busy;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    checks++;
    if (rd_data !== e.rd) begin
      errors++;
      $display("FAIL %s rd_data: got %h expected %h", name, rd_data, e.rd);
    end
    checks++;
    if (busy !== e.bsy) begin
      errors++;
      $display("FAIL %s busy: got %h expected %h", name, busy, e.bsy);
    end
  endtask

  task automatic test_reset();
    // Dirty some state first.
    idle();
    we = 1'b1; waddr = 5'd9; wdata = 32'h1234_5678;
    busy_set = 1'b1; busy_addr = 5'd4; rd_en = 1'b1; rd_addr = {5'd4, 5'd9};
    step("reset_prep");
    idle();
    rd_en = 1'b1; rd_addr = {5'd4, 5'd9};
    step("reset_prep_read");
    // Assert reset mid-cycle with inputs active; outputs clear without an edge.
    #2;
    Reset = 1'b0;
    we = 1'b1; waddr = 5'd12; wdata = 32'hCAFE_F00D; busy_set = 1'b1; busy_addr = 5'd12;
    #1;
    checks++;
    if (rd_data !== 64'd0) begin errors++; $display("FAIL reset_async rd_data: got %h expected 0", rd_data); end
    checks++;
    if (busy !== 32'd0) begin errors++; $display("FAIL reset_async busy: got %h expected 0", busy); end
    checks++;
    if (rd_hazard !== 2'b00) begin errors++; $display("FAIL reset_async rd_hazard: got %b expected 00", rd_hazard); end
    // Hold reset across an edge with writes pending; nothing may commit.
    @(posedge clk);
    link_we = 1'b1; link_wdata = 32'h5555_AAAA;
    #1;
    checks++;
    if (rd_data !== 64'd0 || busy !== 32'd0) begin
      errors++; $display("FAIL reset_held: got rd_data %h busy %h expected 0", rd_data, busy);
    end
    idle();
    model_clear();
    #2;
    Reset = 1'b1;
    @(posedge clk);
    #1;
    // All registers read back as zero after release.
    for (int a = 1; a < 32; a += 2) begin
      rd_en = 1'b1;
      rd_addr = {5'(a + 1), 5'(a)};
      step("reset_readback");
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; rd_en = 1'b1; rd_addr = {5'd0, 5'd5};
    step("bypass_same_edge");
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_value: got %h expected deadbeef", rd_data[31:0]); end
    idle();
    rd_en = 1'b1; rd_addr = {5'd5, 5'd1};
    step("bypass_later_read");
    checks++;
    if (rd_data[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_later: got %h expected deadbeef", rd_data[63:32]); end
    idle();
  endtask

  task automatic test_link();
    idle();
    we = 1'b1; waddr = 5'd31; wdata = 32'h11;
    link_we = 1'b1; link_wdata = 32'h0040_0008;
    rd_en = 1'b1; rd_addr = {5'd31, 5'd31};
    step("link_collision");
    checks++;
    if (rd_data !== {32'h0040_0008, 32'h0040_0008}) begin
      errors++; $display("FAIL link_wins: got %h expected 0040000800400008", rd_data);
    end
    // Link and writeback to different registers both commit.
    idle();
    we = 1'b1; waddr = 5'd8; wdata = 32'h8888_0008;
    link_we = 1'b1; link_wdata = 32'h0040_0100;
    rd_en = 1'b1; rd_addr = {5'd8, 5'd31};
    step("link_dual_write");
    idle();
    rd_en = 1'b1; rd_addr = {5'd31, 5'd8};
    step("link_dual_readback");
    checks++;
    if (rd_data !== {32'h0040_0100, 32'h8888_0008}) begin
      errors++; $display("FAIL link_dual: got %h expected 0040010088880008", rd_data);
    end
    idle();
  endtask

  task automatic test_zero_reg();
    idle();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    busy_set = 1'b1; busy_addr = 5'd0;
    step("zero_write");
    idle();
    rd_en = 1'b1; rd_addr = {5'd0, 5'd0};
    step("zero_read");
    checks++;
    if (rd_data !== 64'd0) begin errors++; $display("FAIL zero_read_value: got %h expected 0", rd_data); end
    checks++;
    if (busy[0] !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy[0]); end
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    busy_set = 1'b1; busy_addr = 5'd7;
    step("sb_set");
    checks++;
    if (busy[7] !== 1'b1) begin errors++; $display("FAIL sb_set_bit: got %b expected 1", busy[7]); end
    idle();
    rd_addr = {5'd3, 5'd7};
    #1;
    checks++;
    if (rd_hazard[0] !== 1'b1) begin errors++; $display("FAIL sb_hazard: got %b expected 1", rd_hazard[0]); end
    step("sb_hazard_idle");
    // Writeback to 7 masks the hazard and clears the bit.
    we = 1'b1; waddr = 5'd7; wdata = 32'h77;
    #1;
    checks++;
    if (rd_hazard[0] !== 1'b0) begin errors++; $display("FAIL sb_hazard_masked: got %b expected 0", rd_hazard[0]); end
    step("sb_clear");
    checks++;
    if (busy[7] !== 1'b0) begin errors++; $display("FAIL sb_clear_bit: got %b expected 0", busy[7]); end
    // Set and clear on the same register: set wins.
    idle();
    busy_set = 1'b1; busy_addr = 5'd7; we = 1'b1; waddr = 5'd7; wdata = 32'h78;
    step("sb_set_wins");
    checks++;
    if (busy[7] !== 1'b1) begin errors++; $display("FAIL sb_set_wins_bit: got %b expected 1", busy[7]); end
    // Re-setting a busy register keeps it at 1; a single clear releases it.
    idle();
    busy_set = 1'b1; busy_addr = 5'd7;
    step("sb_reset_busy");
    idle();
    we = 1'b1; waddr = 5'd7; wdata = 32'h79;
    step("sb_single_clear");
    // Link port clears busy[31]; link hazard masking.
    idle();
    busy_set = 1'b1; busy_addr = 5'd31;
    step("sb_set31");
    idle();
    rd_addr = {5'd31, 5'd0};
    link_we = 1'b1; link_wdata = 32'h0040_0200;
    step("sb_link_clear");
    idle();
  endtask

  task automatic test_stall();
    idle();
    we = 1'b1; waddr = 5'd3; wdata = 32'hA; rd_en = 1'b1; rd_addr = {5'd0, 5'd3};
    step("stall_first_read");
    checks++;
    if (rd_data[31:0] !== 32'hA) begin errors++; $display("FAIL stall_first: got %h expected a", rd_data[31:0]); end
    idle();
    rd_en = 1'b0; rd_addr = {5'd0, 5'd3}; we = 1'b1; waddr = 5'd3; wdata = 32'hB;
    step("stall_hold");
    checks++;
    if (rd_data[31:0] !== 32'hA) begin errors++; $display("FAIL stall_hold_value: got %h expected a", rd_data[31:0]); end
    idle();
    rd_en = 1'b1; rd_addr = {5'd0, 5'd3};
    step("stall_release");
    checks++;
    if (rd_data[31:0] !== 32'hB) begin errors++; $display("FAIL stall_release_value: got %h expected b", rd_data[31:0]); end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      rd_en      = ($urandom_range(0, 3) != 0);
      rd_addr    = 10'($urandom);
      we         = $urandom_range(0, 1) == 1;
      waddr      = 5'($urandom);
      wdata      = $urandom;
      link_we    = ($urandom_range(0, 5) == 0);
      link_wdata = $urandom;
      busy_set   = $urandom_range(0, 1) == 1;
      busy_addr  = 5'($urandom);
      step("random");
    end
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    model_clear();
    Reset = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    Reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rd_data !== 64'd0 || busy !== 32'd0) begin
      errors++; $display("FAIL power_on: got rd_data %h busy %h expected 0", rd_data, busy);
    end
    test_reset();
    test_bypass();
    test_link();
    test_zero_reg();
    test_scoreboard();
    test_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the pipelined CPU.
- Successor to the two-read/one-write file. Adds a configurable data width, depth and read-port count.
- Adds a dedicated link-write port for jal, write-first bypass into registered read ports, read-enable hold for pipeline stalls, and a per-register busy scoreboard for hazard detection.
- Sits between decode (reads, busy set) and writeback (writes, busy clear).

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of architectural registers; must be a power of two, at least 2.
- AW, log2(DEPTH) = 5, register address width.
- NR, 2, number of read ports (1..4).
- LINK_REG, 31, register written by the link port.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- rd_en  in  1  read enable shared by all read ports; 0 holds the read outputs (stall).
- rd_addr  in  NR*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NR*DW  registered read data, one DW slice per port.
- rd_hazard  out  NR  combinational; 1 = the addressed register is busy and is not being written this cycle.
- we  in  1  writeback write enable.
- waddr  in  AW  writeback address.
- wdata  in  DW  writeback data.
- link_we  in  1  link (jal) write enable.
- link_wdata  in  DW  link data, i.e. the return address.
- busy_set  in  1  marks a destination register as pending.
- busy_addr  in  AW  destination address to mark.
- busy  out  DEPTH  registered scoreboard vector.

Behaviour:
- Reset low (asynchronous):
  - All registers cleared to 0.
  - rd_data = 0, busy = 0.
  - rd_hazard follows busy, so it is 0.
- Register 0:
  - Reads always return 0.
  - Writes to register 0 are ignored.
  - busy[0] is never set.
- Write, at the rising edge:
  - we=1 and waddr!=0: reg[waddr] <= wdata.
  - link_we=1: reg[LINK_REG] <= link_wdata.
  - Both target the same register: the link port wins.
  - Both target different registers: both writes occur.
- Read, at the rising edge, per port k:
  - rd_en=1: rd_data[k] <= value of reg[rd_addr[k]] after this edge's writes (write-first bypass). Bypass priority: link > writeback > array.
  - rd_en=0: rd_data[k] holds its previous value. Writes still commit; a held stale value is not refreshed.
- Latency:
  - Read: 1 cycle from address sampling to rd_data.
  - Write-to-read: 0 cycles, because same-edge data is visible through the bypass.
- Scoreboard, at the rising edge:
  - Set: busy_set=1 and busy_addr!=0 -> busy[busy_addr] <= 1.
  - Clear: we=1 and waddr!=0 -> busy[waddr] <= 0.
  - Link clear: link_we=1 -> busy[LINK_REG] <= 0.
  - Set and clear on the same address in the same cycle: set wins, since a new producer is issued.
  - busy_set on an already-busy register: stays 1; no counting.
- rd_hazard[k] (combinational):
  - = busy[rd_addr[k]] AND NOT (we AND waddr==rd_addr[k] AND waddr!=0) AND NOT (link_we AND rd_addr[k]==LINK_REG).
  - Forced 0 when rd_addr[k]==0.
- Out-of-range addresses: cannot occur, because DEPTH is a power of two.
- Reset asserted mid-operation:
  - In-flight writes at that edge are lost.
  - Outputs go to 0 without waiting for CLK.
  - Release is synchronous to the next edge; the first edge with Reset=1 behaves normally.

Decomposition:
- Shared package (cpu_pkg):
  - Constants REG_DW=32, REG_NUM=32, REG_AW=5, REG_LINK=31, REG_ZERO=0.
  - Function clog2 for the AW default.
- One natural sub-module, regfile_scoreboard: the busy vector with its set/clear priority and the rd_hazard generation.
- The storage array and the bypass read ports stay in regfile_mp.

Test Plan:
- Reset=0 with arbitrary inputs toggling -> rd_data=0 and busy=0 immediately, without waiting for CLK. After release, reading registers 1..31 returns 0.
- we=1, waddr=5, wdata=32'hDEADBEEF, rd_en=1, rd_addr0=5 on the same edge -> rd_data0=32'hDEADBEEF after that edge (bypass). A later read of 5 returns the same value.
- we=1, waddr=31, wdata=32'h11 together with link_we=1, link_wdata=32'h0040_0008 -> reg31=32'h0040_0008, and rd_data returns 32'h0040_0008.
- we=1, waddr=0, wdata=32'hFFFF_FFFF, then read 0 on both ports -> rd_data0=rd_data1=0. busy_set with busy_addr=0 leaves busy[0]=0.
- busy_set at addr 7 -> busy[7]=1 and rd_hazard0=1 for rd_addr0=7. A same-cycle we to 7 drops rd_hazard0 to 0, and busy[7]=0 after the edge. busy_set and we both to 7 in one cycle -> busy[7] stays 1.
- rd_en=1 reading reg 3 = 32'hA, then rd_en=0 while we writes 32'hB to reg 3 -> rd_data0 holds 32'hA. Re-asserting rd_en -> rd_data0=32'hB.
